inst_encoder: RTL and testbench

Instruction encoder and streaming program loader for the single-cycle MIPS core; it is the inverse of the control decoder. It accepts symbolic instruction requests (op selector plus register, shamt, immediate and target fields) and packs them into 32-bit MIPS machine words. Encoded words are buffered in a small FIFO and streamed out with a running byte address, so testbenches and the boot loader can fill instruction memory.

---
 rtl/inst_encoder.sv | 134 +++++++++++++
 tb/tb_inst_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - MIPS instruction encoder with output FIFO and byte-address counter
module inst_encoder #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       emit_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       emit_q, emit_d;
  logic              err_q, err_d;

  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              accept;
  logic              push;
  logic              pop;

  // Pack the symbolic request into a machine word; enc_ok drops for unknown ops.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (req_op)
      5'd0:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h20};
      5'd1:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h22};
      5'd2:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h24};
      5'd3:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h25};
      5'd4:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h27};
      5'd5:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h26};
      5'd6:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h2A};
      5'd7:  enc_word = {6'h00, 5'h0, req_rt, req_rd, req_shamt, 6'h00};
      5'd8:  enc_word = {6'h00, 5'h0, req_rt, req_rd, req_shamt, 6'h02};
      5'd9:  enc_word = {6'h00, req_rs, 15'h0, 6'h08};
      5'd10: enc_word = {6'h00, req_rs, 5'h0, req_rd, 5'h0, 6'h09};
      5'd11: enc_word = {6'h23, req_rs, req_rt, req_imm};
      5'd12: enc_word = {6'h21, req_rs, req_rt, req_imm};
      5'd13: enc_word = {6'h2B, req_rs, req_rt, req_imm};
      5'd14: enc_word = {6'h29, req_rs, req_rt, req_imm};
      5'd15: enc_word = {6'h04, req_rs, req_rt, req_imm};
      5'd16: enc_word = {6'h05, req_rs, req_rt, req_imm};
      5'd17: enc_word = {6'h08, req_rs, req_rt, req_imm};
      5'd18: enc_word = {6'h0C, req_rs, req_rt, req_imm};
      5'd19: enc_word = {6'h0A, req_rs, req_rt, req_imm};
      5'd20: enc_word = {6'h02, req_target};
      5'd21: enc_word = {6'h03, req_target};
      default: enc_ok = 1'b0;
    endcase
  end

  assign req_ready = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_inst  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign emit_cnt  = emit_q;

  // Unsupported ops still complete the handshake but never reach the FIFO.
  assign accept = req_valid && req_ready;
  assign push   = accept && enc_ok;
  assign pop    = out_valid && out_ready;

  // Next-state for pointers, occupancy, address counter and status.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (addr_load) begin
      addr_d = addr_value;
    end else if (pop) begin
      addr_d = addr_q + ADDR_W'(4);
    end else begin
      addr_d = addr_q;
    end
    emit_d = pop ? emit_q + 16'd1 : emit_q;
    err_d  = err_q | (accept && !enc_ok);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      emit_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      emit_q   <= emit_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; stale entries are unreachable once occupancy is cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op, req_rs, req_rt, req_rd, req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] emit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  inst_encoder #(.FIFO_DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_shamt  (req_shamt),
    .req_imm    (req_imm),
    .req_target (req_target),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .err        (err),
    .emit_cnt   (emit_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid = 1'b0;
    addr_load = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic set_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_imm = imm; req_target = tgt;
  endtask

  task automatic push(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    bit acc = 0;
    set_req(op, rs, rt, rd, sh, imm, tgt);
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!acc) check("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp_inst, input logic [31:0] exp_addr);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_inst"}, 64'(out_inst), 64'(exp_inst));
    check({tag, "_addr"}, 64'(out_addr), 64'(exp_addr));
    tick();
  endtask

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    addr_value = 32'h0;
    do_reset();

    // Reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_emit", 64'(emit_cnt), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);

    // 1: single ADD, 1-cycle latency, then consumed
    out_ready = 1'b1;
    push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_inst", 64'(out_inst), 64'h00221820);
    check("t1_addr", 64'(out_addr), 64'h0);
    tick();
    check("t1_valid_after", 64'(out_valid), 64'd0);
    check("t1_emit", 64'(emit_cnt), 64'd1);
    check("t1_addr_after", 64'(out_addr), 64'h4);

    // 2: back-to-back requests buffered then drained
    do_reset();
    push(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    push(5'd17, 5'd0, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    push(5'd7, 5'd0, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0);
    expect_word("t2_lw", 32'h8FA80004, 32'h0);
    expect_word("t2_addi", 32'h2002FFFF, 32'h4);
    expect_word("t2_sll", 32'h00052080, 32'h8);
    check("t2_emit", 64'(emit_cnt), 64'd3);

    // 3: fill FIFO, check backpressure and ordering
    do_reset();
    push(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    push(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    push(5'd9, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    check("t3_full_ready", 64'(req_ready), 64'd0);
    set_req(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'h0);
    req_valid = 1'b1;
    tick();
    check("t3_hold_ready", 64'(req_ready), 64'd0);
    check("t3_hold_inst", 64'(out_inst), 64'h08000010);
    check("t3_hold_addr", 64'(out_addr), 64'h0);
    out_ready = 1'b1;
    check("t3_no_passthru", 64'(req_ready), 64'd0);
    tick();
    check("t3_space_ready", 64'(req_ready), 64'd1);
    check("t3_w2_inst", 64'(out_inst), 64'h00221820);
    check("t3_w2_addr", 64'(out_addr), 64'h4);
    tick();
    req_valid = 1'b0;
    expect_word("t3_w3", 32'h00853022, 32'h8);
    expect_word("t3_w4", 32'h03E00008, 32'hC);
    expect_word("t3_w5", 32'h1022FFFE, 32'h10);
    check("t3_empty", 64'(out_valid), 64'd0);
    check("t3_emit", 64'(emit_cnt), 64'd5);

    // 4: unsupported op dropped and flagged
    do_reset();
    push(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
    check("t4_err_before", 64'(err), 64'd0);
    push(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    check("t4_err_set", 64'(err), 64'd1);
    push(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
    expect_word("t4_jal0", 32'h0C000040, 32'h0);
    expect_word("t4_jal1", 32'h0C000040, 32'h4);
    check("t4_empty", 64'(out_valid), 64'd0);
    check("t4_emit", 64'(emit_cnt), 64'd2);
    check("t4_err_sticky", 64'(err), 64'd1);

    // 5: addr_load wins over a concurrent pop, then wraps
    do_reset();
    push(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    push(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    addr_value = 32'hFFFFFFFC;
    addr_load = 1'b1;
    out_ready = 1'b1;
    check("t5_or_inst", 64'(out_inst), 64'h00221825);
    tick();
    addr_load = 1'b0;
    check("t5_load_addr", 64'(out_addr), 64'hFFFFFFFC);
    check("t5_load_emit", 64'(emit_cnt), 64'd1);
    check("t5_nor_inst", 64'(out_inst), 64'h00221827);
    tick();
    check("t5_wrap_addr", 64'(out_addr), 64'h0);
    check("t5_wrap_emit", 64'(emit_cnt), 64'd2);
    check("t5_empty", 64'(out_valid), 64'd0);

    // 6: reset mid-stream discards everything
    do_reset();
    push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    push(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    push(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    push(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    out_ready = 1'b1;
    tick();
    check("t6_pre_err", 64'(err), 64'd1);
    check("t6_pre_emit", 64'(emit_cnt), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_addr", 64'(out_addr), 64'h0);
    check("t6_emit", 64'(emit_cnt), 64'd0);
    check("t6_err", 64'(err), 64'd0);
    check("t6_ready", 64'(req_ready), 64'd1);

    // 7: remaining encodings, one at a time
    do_reset();
    vecs.push_back('{5'd2,  5'd1,  5'd2, 5'd3,  5'd0, 16'h0,    26'h0, 32'h00221824});
    vecs.push_back('{5'd5,  5'd1,  5'd2, 5'd3,  5'd0, 16'h0,    26'h0, 32'h00221826});
    vecs.push_back('{5'd6,  5'd1,  5'd2, 5'd3,  5'd0, 16'h0,    26'h0, 32'h0022182A});
    vecs.push_back('{5'd7,  5'd7,  5'd5, 5'd4,  5'd2, 16'h0,    26'h0, 32'h00052080});
    vecs.push_back('{5'd8,  5'd0,  5'd5, 5'd4,  5'd2, 16'h0,    26'h0, 32'h00052082});
    vecs.push_back('{5'd10, 5'd9,  5'd0, 5'd31, 5'd0, 16'h0,    26'h0, 32'h0120F809});
    vecs.push_back('{5'd12, 5'd29, 5'd8, 5'd0,  5'd0, 16'h0004, 26'h0, 32'h87A80004});
    vecs.push_back('{5'd13, 5'd29, 5'd8, 5'd0,  5'd0, 16'h0004, 26'h0, 32'hAFA80004});
    vecs.push_back('{5'd14, 5'd29, 5'd8, 5'd0,  5'd0, 16'h0004, 26'h0, 32'hA7A80004});
    vecs.push_back('{5'd16, 5'd1,  5'd2, 5'd0,  5'd0, 16'hFFFE, 26'h0, 32'h1422FFFE});
    vecs.push_back('{5'd18, 5'd1,  5'd2, 5'd0,  5'd0, 16'h00FF, 26'h0, 32'h302200FF});
    vecs.push_back('{5'd19, 5'd1,  5'd2, 5'd0,  5'd0, 16'h8000, 26'h0, 32'h28228000});
    foreach (vecs[i]) begin
      push(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      expect_word($sformatf("t7_op%0d", vecs[i].op), vecs[i].exp, 32'(i * 4));
    end
    check("t7_emit", 64'(emit_cnt), 64'(vecs.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
